// File: rtl/aes_decrypt_scheduler_pkg.sv
// Shared types and constants for the AES-128 decrypt scheduler.
package aes_sched_pkg;

    localparam int unsigned BLOCK_W      = 128;
    localparam int unsigned CORE_LATENCY = 11;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [2:0] {
        ST_RECOVER = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_ARM     = 3'd3,
        ST_BUSY    = 3'd4,
        ST_RESP    = 3'd5
    } sched_state_t;

endpackage

// File: rtl/aes_decrypt_scheduler_if.sv
// Request, response and core-side signals of the decrypt scheduler.
interface aes_decrypt_scheduler_if
    import aes_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*BLOCK_W-1:0] req_data;
    logic                       out_valid;
    logic                       out_ready;
    block_t                     out_data;
    logic [ID_W-1:0]            out_id;
    logic                       core_command;
    block_t                     core_data;
    block_t                     core_result;
    logic                       core_done;

    // Scheduler side
    modport master (
        input  req_valid, req_data, out_ready, core_result, core_done,
        output req_ready, out_valid, out_data, out_id, core_command, core_data
    );

    // Requesters, consumer and core side
    modport slave (
        output req_valid, req_data, out_ready, core_result, core_done,
        input  req_ready, out_valid, out_data, out_id, core_command, core_data
    );
endinterface

// File: rtl/aes_decrypt_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_vld
);

    // Scan from ptr upward, taking the first valid requester
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (en && !grant_vld && req[ID_W'(idx)]) begin
                grant_vld            = 1'b1;
                grant[ID_W'(idx)]    = 1'b1;
                grant_idx            = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/aes_decrypt_scheduler.sv
// Round-robin scheduler sharing one iterative AES-128 decrypt core.
module aes_decrypt_scheduler
    import aes_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned RECOVER_CYC = CORE_LATENCY + 1,
    parameter int unsigned TIMEOUT     = 32
) (
    input  logic                    Clock,
    input  logic                    Reset,
    aes_decrypt_scheduler_if.master bus,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int unsigned CNT_MAX = (TIMEOUT > RECOVER_CYC) ? TIMEOUT : RECOVER_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    sched_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               core_command_q, core_command_d;
    block_t             core_data_q, core_data_d;
    logic               out_valid_q, out_valid_d;
    block_t             out_data_q, out_data_d;
    logic [ID_W-1:0]    out_id_q, out_id_d;
    logic               timeout_q, timeout_d;
    logic               busy_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_vld;
    logic               recover_last;
    logic               op_expired;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_q),
        .en        (state_q == ST_IDLE),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign recover_last = (cnt_q == CNT_W'(RECOVER_CYC - 1));
    assign op_expired   = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_RECOVER;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; timeout is checked ahead of ARM->BUSY, behind BUSY->RESP
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RECOVER: if (recover_last) state_d = ST_IDLE;
            ST_IDLE:    if (grant_vld) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_ARM;
            ST_ARM: begin
                if (op_expired)          state_d = ST_RECOVER;
                else if (!bus.core_done) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (bus.core_done)   state_d = ST_RESP;
                else if (op_expired) state_d = ST_RECOVER;
            end
            ST_RESP:    if (bus.out_ready) state_d = ST_IDLE;
            default:    state_d = ST_RECOVER;
        endcase
    end

    // Next values of counter, pointer and the registered outputs
    always_comb begin
        cnt_d          = cnt_q;
        rr_ptr_d       = rr_ptr_q;
        core_command_d = 1'b0;
        core_data_d    = core_data_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_id_d       = out_id_q;
        timeout_d      = timeout_q;
        unique case (state_q)
            ST_RECOVER: begin
                cnt_d = recover_last ? '0 : cnt_q + CNT_W'(1);
            end
            ST_IDLE: begin
                if (grant_vld) begin
                    core_data_d    = bus.req_data[BLOCK_W*32'(grant_idx) +: BLOCK_W];
                    out_id_d       = grant_idx;
                    rr_ptr_d       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                    core_command_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
            end
            ST_ARM, ST_BUSY: begin
                if (state_q == ST_BUSY && bus.core_done) begin
                    out_data_d  = bus.core_result;
                    out_valid_d = 1'b1;
                end else if (op_expired) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q          <= '0;
            rr_ptr_q       <= '0;
            core_command_q <= 1'b0;
            core_data_q    <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_id_q       <= '0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b1;
        end else begin
            cnt_q          <= cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            core_command_q <= core_command_d;
            core_data_q    <= core_data_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_id_q       <= out_id_d;
            timeout_q      <= timeout_d;
            busy_q         <= (state_d != ST_IDLE);
        end
    end

    assign bus.req_ready    = grant;
    assign bus.core_command = core_command_q;
    assign bus.core_data    = core_data_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_id       = out_id_q;
    assign busy             = busy_q;
    assign timeout_err      = timeout_q;

endmodule

// File: tb/tb_aes_decrypt_scheduler.sv
// Directed bench for aes_decrypt_scheduler with a behavioural decrypt-core stub.
module tb_aes_decrypt_scheduler;
    import aes_sched_pkg::*;

    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic timeout_err;

    aes_decrypt_scheduler_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    aes_decrypt_scheduler #(
        .NUM_REQ     (4),
        .ID_W        (2),
        .RECOVER_CYC (12),
        .TIMEOUT     (32)
    ) dut (
        .Clock       (clk),
        .Reset       (rst),
        .bus         (bus.master),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Core stub: FIPS-197 vector (key 000102..0f) by lookup, otherwise a fixed XOR.
    // mode 0 normal, 1 stale done held 3 cycles past start, 2 never completes.
    int           mode = 0;
    logic         cmd_prev = 1'b0;
    logic         run = 1'b0;
    int           ccnt = 0;
    logic         done_r = 1'b0;
    logic [127:0] lat_data = '0;
    logic [127:0] result_r = '0;

    function automatic logic [127:0] core_model(input logic [127:0] d);
        if (d == FIPS_CT) return FIPS_PT;
        return d ^ {4{32'hdeadbeef}};
    endfunction

    always @(posedge clk) begin
        cmd_prev <= bus.core_command;
        if (bus.core_command && !cmd_prev) begin
            run      <= 1'b1;
            ccnt     <= 1;
            lat_data <= bus.core_data;
            if (mode != 1) done_r <= 1'b0;
        end else if (run) begin
            ccnt <= ccnt + 1;
            if (mode == 1 && ccnt == 3) done_r <= 1'b0;
            if (mode != 2 && ccnt == 10) begin
                done_r   <= 1'b1;
                result_r <= core_model(lat_data);
                run      <= 1'b0;
            end
        end
    end

    assign bus.core_done   = done_r;
    assign bus.core_result = result_r;

    // Monitors: grants, command-high cycles, delivered outputs
    int           cmd_pulses = 0;
    int           grant_q[$];
    int           oid_q[$];
    logic [127:0] odata_q[$];

    always @(posedge clk) begin
        if (bus.core_command) cmd_pulses <= cmd_pulses + 1;
        for (int i = 0; i < 4; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) grant_q.push_back(i);
        end
        if (bus.out_valid && bus.out_ready) begin
            oid_q.push_back(int'(bus.out_id));
            odata_q.push_back(bus.out_data);
        end
    end

    int total = 0;
    int passed = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] rr_data(input int i);
        return {4{32'h01010101 * 32'(i + 1)}};
    endfunction

    // Wait for an accept (core_command rises), then verify 12-edge latency and payload
    task automatic do_op(input int idx, input logic [127:0] data, input string tag);
        int n;
        int early;
        bus.req_valid[idx]              = 1'b1;
        bus.req_data[idx*128 +: 128]    = data;
        n = 0;
        while (bus.core_command !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_accept"}, 128'(n < 60), 128'(1));
        bus.req_valid[idx] = 1'b0;
        check({tag, "_core_data"}, bus.core_data, data);
        check({tag, "_id_latched"}, 128'(bus.out_id), 128'(idx));
        tick();
        check({tag, "_cmd_one_cycle"}, 128'(bus.core_command), 128'(0));
        early = 0;
        repeat (10) begin
            tick();
            if (bus.out_valid !== 1'b0) early++;
        end
        check({tag, "_no_early_valid"}, 128'(early), 128'(0));
        tick();
        check({tag, "_out_valid"}, 128'(bus.out_valid), 128'(1));
        check({tag, "_out_data"}, bus.out_data, core_model(data));
        check({tag, "_out_id"}, 128'(bus.out_id), 128'(idx));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        int bad2;
        int base_g;
        int base_o;
        int base_p;
        logic [127:0] hold_data;
        int exp_g[5] = '{0, 1, 2, 3, 0};

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_core_command", 128'(bus.core_command), 128'(0));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_data", bus.out_data, 128'(0));
        check("rst_out_id", 128'(bus.out_id), 128'(0));
        check("rst_core_data", bus.core_data, 128'(0));
        check("rst_timeout", 128'(timeout_err), 128'(0));
        check("rst_req_ready", 128'(bus.req_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(1));

        // FIPS-197 vector from requester 2; grant only after 12 RECOVER cycles
        rst = 1'b0;
        bus.req_valid[2]        = 1'b1;
        bus.req_data[256 +: 128] = FIPS_CT;
        bad = 0;
        repeat (11) begin
            tick();
            if (bus.req_ready !== 4'b0000 || bus.core_command !== 1'b0) bad++;
        end
        check("recover_no_grant", 128'(bad), 128'(0));
        tick();
        check("idle_grant2", 128'(bus.req_ready), 128'(4'b0100));
        check("idle_busy", 128'(busy), 128'(0));
        tick();
        check("fips_cmd", 128'(bus.core_command), 128'(1));
        check("fips_core_data", bus.core_data, FIPS_CT);
        check("fips_issue_no_grant", 128'(bus.req_ready), 128'(0));
        bus.req_valid = '0;
        tick();
        check("fips_cmd_low", 128'(bus.core_command), 128'(0));
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.out_valid !== 1'b0) bad++;
        end
        check("fips_no_early", 128'(bad), 128'(0));
        tick();
        check("fips_valid", 128'(bus.out_valid), 128'(1));
        check("fips_pt", bus.out_data, FIPS_PT);
        check("fips_id", 128'(bus.out_id), 128'(2));

        // Backpressure in RESP with all requesters valid
        bus.req_valid = 4'b1111;
        hold_data = bus.core_data;
        bad = 0;
        bad2 = 0;
        repeat (20) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_data !== FIPS_PT || bus.out_id !== 2'd2) bad++;
            if (bus.req_ready !== 4'b0000 || bus.core_command !== 1'b0 || bus.core_data !== hold_data) bad2++;
        end
        check("bp_out_stable", 128'(bad), 128'(0));
        check("bp_no_grant", 128'(bad2), 128'(0));
        bus.out_ready = 1'b1;
        bus.req_valid = '0;
        tick();
        check("bp_release", 128'(bus.out_valid), 128'(0));
        check("bp_release_busy", 128'(busy), 128'(0));

        // Round-robin from a fresh pointer with all four valid
        do_reset();
        repeat (12) tick();
        for (int i = 0; i < 4; i++) bus.req_data[i*128 +: 128] = rr_data(i);
        base_g = grant_q.size();
        base_o = oid_q.size();
        base_p = cmd_pulses;
        bus.req_valid = 4'b1111;
        n = 0;
        while (oid_q.size() - base_o < 5 && n < 200) begin
            tick();
            n++;
        end
        bus.req_valid = '0;
        check("rr_done", 128'(n < 200), 128'(1));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_grant%0d", i), 128'(grant_q[base_g+i]), 128'(exp_g[i]));
            check($sformatf("rr_id%0d", i), 128'(oid_q[base_o+i]), 128'(exp_g[i]));
            check($sformatf("rr_data%0d", i), odata_q[base_o+i], core_model(rr_data(exp_g[i])));
        end
        check("rr_cmd_pulses", 128'(cmd_pulses - base_p), 128'(5));

        // Stale done still high when the next op starts
        tick();
        mode = 1;
        do_op(1, 128'hfeedface_0badf00d_12345678_9abcdef0, "stale");
        mode = 0;

        // Core never completes -> timeout, RECOVER, then service resumes
        tick();
        mode = 2;
        bus.req_valid[0]     = 1'b1;
        bus.req_data[0 +: 128] = 128'h1;
        n = 0;
        while (bus.core_command !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("to_accept", 128'(n < 60), 128'(1));
        bus.req_valid = '0;
        repeat (32) tick();
        check("to_not_yet", 128'(timeout_err), 128'(0));
        tick();
        check("to_err", 128'(timeout_err), 128'(1));
        check("to_no_valid", 128'(bus.out_valid), 128'(0));
        check("to_busy", 128'(busy), 128'(1));
        mode = 0;
        bus.req_valid[3]         = 1'b1;
        bus.req_data[384 +: 128] = 128'h3333_0000_3333_0000_3333_0000_3333_0000;
        bad = 0;
        repeat (11) begin
            tick();
            if (bus.req_ready !== 4'b0000) bad++;
        end
        check("to_recover_no_grant", 128'(bad), 128'(0));
        tick();
        check("to_grant3", 128'(bus.req_ready), 128'(4'b1000));
        do_op(3, 128'h3333_0000_3333_0000_3333_0000_3333_0000, "after_to");
        check("to_sticky", 128'(timeout_err), 128'(1));

        // Reset 5 cycles into BUSY abandons the op
        tick();
        bus.req_valid[1]         = 1'b1;
        bus.req_data[128 +: 128] = 128'haaaa;
        n = 0;
        while (bus.core_command !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("mr_accept", 128'(n < 60), 128'(1));
        bus.req_valid = '0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_timeout_clr", 128'(timeout_err), 128'(0));
        check("mr_core_data_clr", bus.core_data, 128'(0));
        check("mr_busy", 128'(busy), 128'(1));
        bad = 0;
        bad2 = 0;
        repeat (20) begin
            tick();
            if (bus.out_valid !== 1'b0) bad++;
            if (bus.core_command !== 1'b0) bad2++;
        end
        check("mr_no_valid", 128'(bad), 128'(0));
        check("mr_cmd_low", 128'(bad2), 128'(0));
        do_op(2, 128'h0f0e0d0c_0b0a0908_07060504_03020100, "after_mr");
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
